// File: rtl/vga_pkg.sv
// Shared VGA constants: default visible area, RGB565 colours, bar and box palettes, no-request code.
// Imported by vga_pic_box and vga_box_motion.
package vga_pkg;

    localparam int H_VALID_DEF = 640;
    localparam int V_VALID_DEF = 480;

    localparam logic [9:0] NO_REQ = 10'h3ff;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_ORANGE = 16'hFC00;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_CYAN   = 16'h07FF;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_PURPLE = 16'hF81F;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;

    // Entry [0] is the rightmost element of each concatenation.
    localparam logic [7:0][15:0] BAR_PALETTE = {RGB_WHITE, RGB_PURPLE, RGB_BLUE, RGB_CYAN,
                                                RGB_GREEN, RGB_YELLOW, RGB_ORANGE, RGB_RED};
    localparam logic [3:0][15:0] BOX_PALETTE = {RGB_BLUE, RGB_GREEN, RGB_RED, RGB_WHITE};

    typedef enum logic {
        DIR_INC = 1'b0,   // right / down
        DIR_DEC = 1'b1    // left / up
    } dir_t;

endpackage

// File: rtl/vga_box_motion.sv
// Box position/direction (and colour index when BOX_COLOR_CYCLE_EN) stepped once per frame end.
// Latency: new position visible the cycle after the frame-end strobe.
// Backpressure: none; pause high at frame end holds all state.
module vga_box_motion
    import vga_pkg::*;
#(
    parameter int H_VALID = H_VALID_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int BOX_W   = 16,
    parameter int BOX_H   = 16,
    parameter int STEP_X  = 2,
    parameter int STEP_Y  = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        frame_end,
    input  logic        pause,
    output logic [9:0]  box_x,
    output logic [9:0]  box_y,
    output logic [15:0] box_color
);

    localparam logic [9:0]  X_LIM = 10'(H_VALID - BOX_W);
    localparam logic [9:0]  Y_LIM = 10'(V_VALID - BOX_H);
    localparam logic [10:0] SX    = 11'(STEP_X);
    localparam logic [10:0] SY    = 11'(STEP_Y);

    dir_t        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic [9:0]  x_nxt, y_nxt;
    logic [10:0] x_ext, y_ext;
    logic        edge_x, edge_y;
    logic        step_en;

    assign x_ext   = {1'b0, box_x};
    assign y_ext   = {1'b0, box_y};
    assign step_en = frame_end && !pause;

    // 11-bit compares so x+STEP can never wrap past the limit.
    assign edge_x = (dir_x == DIR_INC) ? (x_ext + SX >= {1'b0, X_LIM}) : (x_ext <= SX);
    assign edge_y = (dir_y == DIR_INC) ? (y_ext + SY >= {1'b0, Y_LIM}) : (y_ext <= SY);

    always_comb begin
        x_nxt     = box_x;
        y_nxt     = box_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        if (dir_x == DIR_INC) begin
            if (edge_x) begin x_nxt = X_LIM; dir_x_nxt = DIR_DEC; end
            else              x_nxt = 10'(x_ext + SX);
        end else begin
            if (edge_x) begin x_nxt = '0; dir_x_nxt = DIR_INC; end
            else              x_nxt = 10'(x_ext - SX);
        end
        if (dir_y == DIR_INC) begin
            if (edge_y) begin y_nxt = Y_LIM; dir_y_nxt = DIR_DEC; end
            else              y_nxt = 10'(y_ext + SY);
        end else begin
            if (edge_y) begin y_nxt = '0; dir_y_nxt = DIR_INC; end
            else              y_nxt = 10'(y_ext - SY);
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= DIR_INC;
            dir_y <= DIR_INC;
        end else if (step_en) begin
            box_x <= x_nxt;
            box_y <= y_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
        end
    end

`ifdef BOX_COLOR_CYCLE_EN
    logic [1:0] color_idx;

    // A corner hit (both axes in one frame) is a single bounce event.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst)
            color_idx <= '0;
        else if (step_en && (edge_x || edge_y))
            color_idx <= color_idx + 2'd1;
    end

    assign box_color = BOX_PALETTE[color_idx];
`else
    assign box_color = RGB_WHITE;
`endif

endmodule

// File: rtl/vga_pic_box.sv
// Pixel source: eight colour bars with a bouncing box; box colour cycles when BOX_COLOR_CYCLE_EN is defined.
// Latency: 1 cycle from pix_x/pix_y to pix_data; frame_done pulses with the frame's last pixel.
// Backpressure: none; a request of 10'h3ff on either axis yields black.
module vga_pic_box
    import vga_pkg::*;
#(
    parameter int H_VALID = H_VALID_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int BAR_W   = 80,
    parameter int BOX_W   = 16,
    parameter int BOX_H   = 16,
    parameter int STEP_X  = 2,
    parameter int STEP_Y  = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pause,
    output logic [15:0] pix_data,
    output logic        frame_done
);

    logic [9:0]  box_x, box_y;
    logic [15:0] box_color;
    logic [15:0] pix_nxt;
    logic [10:0] px, py, bx, by;
    logic [2:0]  bar_idx;
    logic        req_vld, box_hit, frame_end;

    assign req_vld   = (pix_x != NO_REQ) && (pix_y != NO_REQ);
    assign frame_end = req_vld && (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

    assign px = {1'b0, pix_x};
    assign py = {1'b0, pix_y};
    assign bx = {1'b0, box_x};
    assign by = {1'b0, box_y};
    assign box_hit = (px >= bx) && (px < bx + 11'(BOX_W)) &&
                     (py >= by) && (py < by + 11'(BOX_H));

    // Descending compare chain leaves the lowest bar whose right edge lies beyond pix_x.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 7; i >= 0; i--)
            if (pix_x < 10'((i + 1) * BAR_W))
                bar_idx = 3'(i);
    end

    always_comb begin
        pix_nxt = RGB_BLACK;
        if (req_vld)
            pix_nxt = box_hit ? box_color : BAR_PALETTE[bar_idx];
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_data   <= pix_nxt;
            frame_done <= frame_end;
        end
    end

    vga_box_motion #(
        .H_VALID (H_VALID),
        .V_VALID (V_VALID),
        .BOX_W   (BOX_W),
        .BOX_H   (BOX_H),
        .STEP_X  (STEP_X),
        .STEP_Y  (STEP_Y)
    ) u_motion (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .frame_end (frame_end),
        .pause     (pause),
        .box_x     (box_x),
        .box_y     (box_y),
        .box_color (box_color)
    );

endmodule
